// File: rtl/coeff_pkg.sv
// Shared types, the default 16-tap coefficient set and the symmetric-read index helper
// for the coefficient bank.
package coeff_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} load_state_t;

  // Palindromic set, so element order is the same whichever way it is indexed.
  localparam logic [15:0][15:0] COEFF_DEFAULT_16 = {
    16'h0565, 16'h0BD9, 16'h0B0B, 16'hFF27, 16'hF3A7, 16'hFB52, 16'h182E, 16'h3384,
    16'h3384, 16'h182E, 16'hFB52, 16'hF3A7, 16'hFF27, 16'h0B0B, 16'h0BD9, 16'h0565
  };

  function automatic int unsigned mirror_idx(input int unsigned k,
                                             input int unsigned ntaps,
                                             input bit          sym);
    if (sym && (k >= ntaps / 2)) return ntaps - 1 - k;
    return k;
  endfunction

endpackage

// File: rtl/coeff_loader.sv
// Load FSM for the shadow bank: accepts a framed word stream, flags framing errors
// and hands over a complete set until a swap consumes it.
module coeff_loader
  import coeff_pkg::*;
#(
  parameter int D  = 16,
  parameter int PW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_valid,
  input  logic          i_wr_last,
  input  logic          i_swap_req,
  output logic          o_wr_ready,
  output logic          o_we,
  output logic [PW-1:0] o_waddr,
  output logic          o_done,
  output logic          o_load_err
);

  load_state_t   state_reg;
  logic [PW-1:0] ptr_reg;
  logic          err_reg;
  logic          xfer;
  logic          at_end;

  assign o_wr_ready = !i_rst && (state_reg != FULL);
  assign xfer       = i_wr_valid && o_wr_ready;
  assign at_end     = (ptr_reg == PW'(D - 1));
  assign o_we       = xfer;
  assign o_waddr    = ptr_reg;
  assign o_done     = (state_reg == FULL);
  assign o_load_err = err_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE, LOAD: begin
          if (xfer) begin
            if (i_wr_last && at_end) begin
              state_reg <= FULL;
              ptr_reg   <= '0;
            end else if (i_wr_last || at_end) begin
              // Mis-framed set: drop it, the partial words are never swappable.
              err_reg   <= 1'b1;
              ptr_reg   <= '0;
              state_reg <= IDLE;
            end else begin
              ptr_reg   <= ptr_reg + 1'b1;
              state_reg <= LOAD;
            end
          end
        end
        FULL: begin
          if (i_swap_req) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/coeff_bank.sv
// Multi-bank FIR coefficient store: the filter reads the active bank while a new
// set streams into the shadow bank, then the banks rotate on a swap request.
module coeff_bank
  import coeff_pkg::*;
#(
  parameter int NTAPS      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int NBANKS     = 2,
  parameter int SYMMETRIC  = 0,
  parameter int PRELOAD    = 1,
  parameter int IDX_WIDTH  = $clog2(NTAPS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rd_en,
  input  logic [IDX_WIDTH-1:0]      i_rd_idx,
  output logic [DATA_WIDTH-1:0]     o_tap,
  output logic                      o_tap_valid,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic                      i_wr_last,
  input  logic                      i_swap_req,
  output logic                      o_swap_ack,
  output logic [$clog2(NBANKS)-1:0] o_active_bank,
  output logic                      o_load_err
);

  localparam int  D           = (SYMMETRIC != 0) ? NTAPS / 2 : NTAPS;
  localparam int  PW          = (D > 1) ? $clog2(D) : 1;
  localparam int  BW          = $clog2(NBANKS);
  localparam bit  USE_PRELOAD = (PRELOAD == 1) && (NTAPS == 16) && (SYMMETRIC == 0);

  logic [DATA_WIDTH-1:0] mem [NBANKS][D];
  logic [BW-1:0]         active_reg;
  logic [BW-1:0]         shadow_bank;
  logic [DATA_WIDTH-1:0] tap_reg;
  logic                  tap_valid_reg;
  logic                  swap_ack_reg;
  logic                  wr_en;
  logic [PW-1:0]         wr_addr;
  logic                  set_done;
  logic                  swap_fire;
  logic                  rd_in_range;
  logic [PW-1:0]         rd_phys;

  coeff_loader #(.D(D), .PW(PW)) u_loader (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_valid (i_wr_valid),
    .i_wr_last  (i_wr_last),
    .i_swap_req (i_swap_req),
    .o_wr_ready (o_wr_ready),
    .o_we       (wr_en),
    .o_waddr    (wr_addr),
    .o_done     (set_done),
    .o_load_err (o_load_err)
  );

  assign shadow_bank = (active_reg == BW'(NBANKS - 1)) ? '0 : active_reg + 1'b1;
  assign swap_fire   = set_done && i_swap_req;
  assign rd_in_range = (32'(i_rd_idx) < NTAPS);
  assign rd_phys     = rd_in_range ? PW'(mirror_idx(32'(i_rd_idx), NTAPS, SYMMETRIC != 0)) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int w = 0; w < D; w++) begin
          mem[b][w] <= (USE_PRELOAD && (b == 0)) ? DATA_WIDTH'(COEFF_DEFAULT_16[w[3:0]]) : '0;
        end
      end
    end else if (wr_en) begin
      mem[shadow_bank][wr_addr] <= i_wr_data;
    end
  end

  // Reads use the pre-swap active bank on the swap edge itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_reg    <= '0;
      swap_ack_reg  <= 1'b0;
      tap_reg       <= '0;
      tap_valid_reg <= 1'b0;
    end else begin
      swap_ack_reg  <= swap_fire;
      if (swap_fire) active_reg <= shadow_bank;
      tap_valid_reg <= i_rd_en;
      if (i_rd_en) tap_reg <= rd_in_range ? mem[active_reg][rd_phys] : '0;
    end
  end

  assign o_tap         = tap_reg;
  assign o_tap_valid   = tap_valid_reg;
  assign o_swap_ack    = swap_ack_reg;
  assign o_active_bank = active_reg;

endmodule

// File: tb/tb_coeff_bank.sv
// Directed bench for coeff_bank: instance 0 is the default preloaded build,
// instance 1 is a symmetric 16-tap build without preload.
module tb_coeff_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_en     [2];
  logic [3:0]  rd_idx    [2];
  logic [15:0] tap       [2];
  logic        tap_valid [2];
  logic        wr_valid  [2];
  logic        wr_ready  [2];
  logic [15:0] wr_data   [2];
  logic        wr_last   [2];
  logic        swap_req  [2];
  logic        swap_ack  [2];
  logic [0:0]  active    [2];
  logic        load_err  [2];

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_def [16] = '{16'h0565, 16'h0BD9, 16'h0B0B, 16'hFF27,
                                16'hF3A7, 16'hFB52, 16'h182E, 16'h3384,
                                16'h3384, 16'h182E, 16'hFB52, 16'hF3A7,
                                16'hFF27, 16'h0B0B, 16'h0BD9, 16'h0565};

  coeff_bank #(.NTAPS(16), .DATA_WIDTH(16), .NBANKS(2), .SYMMETRIC(0), .PRELOAD(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_en(rd_en[0]), .i_rd_idx(rd_idx[0]), .o_tap(tap[0]), .o_tap_valid(tap_valid[0]),
    .i_wr_valid(wr_valid[0]), .o_wr_ready(wr_ready[0]), .i_wr_data(wr_data[0]),
    .i_wr_last(wr_last[0]), .i_swap_req(swap_req[0]), .o_swap_ack(swap_ack[0]),
    .o_active_bank(active[0]), .o_load_err(load_err[0])
  );

  coeff_bank #(.NTAPS(16), .DATA_WIDTH(16), .NBANKS(2), .SYMMETRIC(1), .PRELOAD(0)) dut_sym (
    .i_clk(clk), .i_rst(rst),
    .i_rd_en(rd_en[1]), .i_rd_idx(rd_idx[1]), .o_tap(tap[1]), .o_tap_valid(tap_valid[1]),
    .i_wr_valid(wr_valid[1]), .o_wr_ready(wr_ready[1]), .i_wr_data(wr_data[1]),
    .i_wr_last(wr_last[1]), .i_swap_req(swap_req[1]), .o_swap_ack(swap_ack[1]),
    .o_active_bank(active[1]), .o_load_err(load_err[1])
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input int s, input int idx, input logic [15:0] exp, input string tag);
    rd_en[s]  = 1'b1;
    rd_idx[s] = 4'(idx);
    tick();
    rd_en[s] = 1'b0;
    chk(tag, tap[s], exp);
    chk({tag, "_valid"}, tap_valid[s], 1);
  endtask

  task automatic load(input int s, input int n, input logic [15:0] base, input int last_at);
    chk("load_ready", wr_ready[s], 1);
    for (int i = 0; i < n; i++) begin
      wr_valid[s] = 1'b1;
      wr_data[s]  = base + 16'(i);
      wr_last[s]  = (i == last_at);
      tick();
    end
    wr_valid[s] = 1'b0;
    wr_last[s]  = 1'b0;
  endtask

  task automatic do_swap(input int s, input logic exp_ack, input string tag);
    swap_req[s] = 1'b1;
    tick();
    swap_req[s] = 1'b0;
    chk(tag, swap_ack[s], exp_ack);
    tick();
    chk({tag, "_drop"}, swap_ack[s], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rd_en[s] = 0; rd_idx[s] = 0; wr_valid[s] = 0; wr_data[s] = 0;
      wr_last[s] = 0; swap_req[s] = 0;
    end
    repeat (3) tick();
    chk("rst_tap", tap[0], 0);
    chk("rst_valid", tap_valid[0], 0);
    chk("rst_ready", wr_ready[0], 0);
    chk("rst_ack", swap_ack[0], 0);
    chk("rst_err", load_err[0], 0);
    chk("rst_active", active[0], 0);
    rst = 1'b0;
    tick();

    // Preloaded defaults in bank 0.
    for (int i = 0; i < 16; i++) rd(0, i, exp_def[i], $sformatf("def_%0d", i));
    tick();
    chk("idle_valid", tap_valid[0], 0);
    chk("idle_hold", tap[0], 16'h0565);

    // Full load into the shadow, reads still see defaults until swap.
    load(0, 16, 16'h0001, 15);
    chk("full_err", load_err[0], 0);
    chk("full_ready", wr_ready[0], 0);
    rd(0, 3, 16'hFF27, "pre_swap_rd");
    do_swap(0, 1, "swap1_ack");
    chk("swap1_active", active[0], 1);
    rd(0, 3, 16'h0004, "post_swap_rd");

    // Short frame: error pulse, swap ignored, then a clean reload.
    load(0, 5, 16'h0050, 4);
    chk("short_err", load_err[0], 1);
    tick();
    chk("short_err_drop", load_err[0], 0);
    chk("short_ready", wr_ready[0], 1);
    do_swap(0, 0, "bad_swap_ack");
    chk("bad_swap_active", active[0], 1);
    load(0, 16, 16'h0100, 15);
    chk("reload_err", load_err[0], 0);
    do_swap(0, 1, "swap2_ack");
    chk("swap2_active", active[0], 0);
    rd(0, 5, 16'h0105, "swap2_rd");

    // Read on the swap edge sees the old bank, the next read the new one.
    load(0, 16, 16'h0200, 15);
    rd_en[0] = 1'b1; rd_idx[0] = 4'd2; swap_req[0] = 1'b1;
    tick();
    swap_req[0] = 1'b0;
    chk("edge_rd_old", tap[0], 16'h0102);
    chk("edge_ack", swap_ack[0], 1);
    chk("edge_active", active[0], 1);
    tick();
    rd_en[0] = 1'b0;
    chk("edge_rd_new", tap[0], 16'h0202);

    // Reset in the middle of a load.
    load(0, 9, 16'h0400, -1);
    rst = 1'b1;
    tick();
    chk("midrst_ready", wr_ready[0], 0);
    chk("midrst_active", active[0], 0);
    chk("midrst_tap", tap[0], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_ready", wr_ready[0], 1);
    rd(0, 4, 16'hF3A7, "postrst_def");
    load(0, 16, 16'h0300, 15);
    chk("postrst_load_err", load_err[0], 0);
    do_swap(0, 1, "postrst_swap_ack");
    chk("postrst_active", active[0], 1);
    rd(0, 0, 16'h0300, "postrst_rd0");
    rd(0, 15, 16'h030F, "postrst_rd15");

    // Symmetric build: 8 stored words mirrored over 16 taps.
    rd(1, 3, 16'h0000, "sym_rst_rd");
    load(1, 8, 16'h000A, 7);
    chk("sym_err", load_err[1], 0);
    chk("sym_full", wr_ready[1], 0);
    do_swap(1, 1, "sym_swap_ack");
    chk("sym_active", active[1], 1);
    rd(1, 15, 16'h000A, "sym_rd15");
    rd(1, 8, 16'h0011, "sym_rd8");
    rd(1, 7, 16'h0011, "sym_rd7");
    rd(1, 0, 16'h000A, "sym_rd0");
    rd(1, 11, 16'h000E, "sym_rd11");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
